// File: rtl/gate_truth_checker_if.sv
// Stimulus/result bus between the gate truth checker and the gate under test.
// The checker side uses the master modport; the gate/host side uses slave.
interface gate_truth_checker_if;
    logic       start;
    logic       c;
    logic       a;
    logic       b;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_vec;
    logic [1:0] idx;

    modport master (
        input  start, c,
        output a, b, busy, done, pass, err_vec, idx
    );

    modport slave (
        output start, c,
        input  a, b, busy, done, pass, err_vec, idx
    );
endinterface

// File: rtl/gate_truth_checker.sv
// Walks a 2-input gate through all four input combinations, holds each for
// HOLD_CYCLES clocks, samples the gate output at the end of each window and
// compares the four samples against the EXPECTED truth table.
module gate_truth_checker #(
    parameter int         HOLD_CYCLES = 100,
    parameter logic [3:0] EXPECTED    = 4'b1000,
    parameter int         CNT_W       = 16
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    gate_truth_checker_if.master  bus
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(HOLD_CYCLES - 1);

    state_t           r_state, w_state;
    logic [CNT_W-1:0] r_cnt,   w_cnt;
    logic [1:0]       r_idx,   w_idx;
    logic [3:0]       r_obs,   w_obs;
    logic             r_a,     w_a;
    logic             r_b,     w_b;
    logic             r_busy,  w_busy;
    logic             r_done,  w_done;
    logic             r_pass,  w_pass;
    logic [3:0]       r_err,   w_err;

    // State and datapath registers; reset abandons any run in progress.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_obs   <= '0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
            r_err   <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_obs   <= w_obs;
            r_a     <= w_a;
            r_b     <= w_b;
            r_busy  <= w_busy;
            r_done  <= w_done;
            r_pass  <= w_pass;
            r_err   <= w_err;
        end
    end

    // Next-state and next-register logic; everything holds unless changed.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_obs   = r_obs;
        w_a     = r_a;
        w_b     = r_b;
        w_busy  = r_busy;
        w_done  = r_done;
        w_pass  = r_pass;
        w_err   = r_err;
        case (r_state)
            S_IDLE, S_DONE: begin
                // A start from DONE clears the previous result on the same edge.
                if (bus.start) begin
                    w_state = S_RUN;
                    w_cnt   = '0;
                    w_idx   = 2'd0;
                    w_obs   = '0;
                    w_a     = 1'b0;
                    w_b     = 1'b0;
                    w_busy  = 1'b1;
                    w_done  = 1'b0;
                    w_pass  = 1'b0;
                    w_err   = '0;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST_CNT) begin
                    // End of hold window: the gate has settled, capture c.
                    w_obs[r_idx] = bus.c;
                    w_cnt        = '0;
                    if (r_idx == 2'd3) begin
                        w_state = S_DONE;
                        w_idx   = 2'd0;
                        w_a     = 1'b0;
                        w_b     = 1'b0;
                        w_busy  = 1'b0;
                        w_done  = 1'b1;
                        w_pass  = (w_obs == EXPECTED);
                        w_err   = w_obs ^ EXPECTED;
                    end else begin
                        w_idx = r_idx + 2'd1;
                        w_a   = w_idx[1];
                        w_b   = w_idx[0];
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
            default: w_state = S_IDLE;
        endcase
    end

    assign bus.a       = r_a;
    assign bus.b       = r_b;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.pass    = r_pass;
    assign bus.err_vec = r_err;
    assign bus.idx     = r_idx;

endmodule

// File: tb/tb_gate_truth_checker.sv
// Bench for gate_truth_checker: one instance with HOLD_CYCLES=100 driving a
// correct AND gate, one with HOLD_CYCLES=4 driving a selectable gate model.
module tb_gate_truth_checker;

    logic clk;
    logic rst100, rst4;
    int   mode;          // 0 AND, 1 OR, 2 stuck0, 3 stuck1, 4 XOR, 5 NAND
    int   n_chk, n_fail;

    gate_truth_checker_if if100 ();
    gate_truth_checker_if if4 ();

    gate_truth_checker #(.HOLD_CYCLES(100), .EXPECTED(4'b1000), .CNT_W(16)) dut100 (
        .i_clk(clk), .i_rst_n(rst100), .bus(if100.master)
    );
    gate_truth_checker #(.HOLD_CYCLES(4), .EXPECTED(4'b1000), .CNT_W(16)) dut4 (
        .i_clk(clk), .i_rst_n(rst4), .bus(if4.master)
    );

    assign if100.c = if100.a & if100.b;

    always_comb begin
        case (mode)
            0:       if4.c = if4.a & if4.b;
            1:       if4.c = if4.a | if4.b;
            2:       if4.c = 1'b0;
            3:       if4.c = 1'b1;
            4:       if4.c = if4.a ^ if4.b;
            default: if4.c = ~(if4.a & if4.b);
        endcase
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int         m;
        logic       exp_pass;
        logic [3:0] exp_err;
        bit         extra;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Start a run on dut4 and check every cycle through the DONE-entry edge.
    task automatic run4(input int m, input logic ep, input logic [3:0] ee, input bit extra);
        mode = m;
        @(negedge clk);
        if4.start = 1'b1;
        @(posedge clk);          // T0
        #1;
        if4.start = 1'b0;
        chk("r4_accept_busy", 32'(if4.busy), 32'd1);
        chk("r4_accept_done", 32'(if4.done), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            if (extra && (k == 5 || k == 10)) begin
                @(negedge clk);
                if4.start = 1'b1;
            end
            @(posedge clk);
            #1;
            if4.start = 1'b0;
            if (k < 16) begin
                chk("r4_busy", 32'(if4.busy), 32'd1);
                chk("r4_done_low", 32'(if4.done), 32'd0);
                chk("r4_ab", 32'({if4.a, if4.b}), 32'(k / 4));
                chk("r4_idx", 32'(if4.idx), 32'(k / 4));
            end else begin
                chk("r4_end_busy", 32'(if4.busy), 32'd0);
                chk("r4_end_done", 32'(if4.done), 32'd1);
                chk("r4_pass", 32'(if4.pass), 32'(ep));
                chk("r4_err", 32'(if4.err_vec), 32'(ee));
                chk("r4_end_ab", 32'({if4.a, if4.b}), 32'd0);
                chk("r4_end_idx", 32'(if4.idx), 32'd0);
            end
        end
        // Result must hold while no start arrives.
        repeat (3) @(posedge clk);
        #1;
        chk("r4_hold_done", 32'(if4.done), 32'd1);
        chk("r4_hold_err", 32'(if4.err_vec), 32'(ee));
    endtask

    initial begin
        int busy_cnt;
        n_chk = 0;
        n_fail = 0;
        mode = 0;
        rst100 = 1'b0;
        rst4 = 1'b0;
        if100.start = 1'b0;
        if4.start = 1'b0;

        vecs[0] = '{m: 0, exp_pass: 1'b1, exp_err: 4'b0000, extra: 1'b0};
        vecs[1] = '{m: 1, exp_pass: 1'b0, exp_err: 4'b0110, extra: 1'b0};
        vecs[2] = '{m: 2, exp_pass: 1'b0, exp_err: 4'b1000, extra: 1'b0};
        vecs[3] = '{m: 3, exp_pass: 1'b0, exp_err: 4'b0111, extra: 1'b0};
        vecs[4] = '{m: 4, exp_pass: 1'b0, exp_err: 4'b1110, extra: 1'b0};
        vecs[5] = '{m: 1, exp_pass: 1'b0, exp_err: 4'b0110, extra: 1'b1};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(if4.busy), 32'd0);
        chk("rst_done", 32'(if4.done), 32'd0);
        chk("rst_pass", 32'(if4.pass), 32'd0);
        chk("rst_err", 32'(if4.err_vec), 32'd0);
        chk("rst_ab", 32'({if4.a, if4.b, if100.a, if100.b}), 32'd0);
        chk("rst_idx", 32'(if4.idx), 32'd0);
        @(negedge clk);
        rst100 = 1'b1;
        rst4 = 1'b1;

        // Long run with the correct gate.
        @(negedge clk);
        if100.start = 1'b1;
        @(posedge clk);
        #1;
        if100.start = 1'b0;
        busy_cnt = 32'(if100.busy);
        chk("r100_ab0", 32'({if100.a, if100.b}), 32'd0);
        for (int k = 1; k < 450; k++) begin
            @(posedge clk);
            #1;
            busy_cnt += 32'(if100.busy);
            if (k < 400 && (k % 100 == 0 || k % 100 == 99))
                chk("r100_ab", 32'({if100.a, if100.b}), 32'(k / 100));
            if (k == 399) chk("r100_done_early", 32'(if100.done), 32'd0);
            if (k == 400) begin
                chk("r100_done", 32'(if100.done), 32'd1);
                chk("r100_pass", 32'(if100.pass), 32'd1);
                chk("r100_err", 32'(if100.err_vec), 32'd0);
            end
        end
        chk("r100_busy_cycles", 32'(busy_cnt), 32'd400);

        // Table-driven short runs, then an immediate re-run from DONE.
        for (int i = 0; i < 6; i++)
            run4(vecs[i].m, vecs[i].exp_pass, vecs[i].exp_err, vecs[i].extra);
        run4(1, 1'b0, 4'b0110, 1'b0);

        // Reset mid-run at T0+6.
        mode = 0;
        @(negedge clk);
        if4.start = 1'b1;
        @(posedge clk);
        #1;
        if4.start = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        rst4 = 1'b0;
        @(posedge clk);
        #1;
        chk("mid_rst_ab", 32'({if4.a, if4.b}), 32'd0);
        chk("mid_rst_busy", 32'(if4.busy), 32'd0);
        chk("mid_rst_done", 32'(if4.done), 32'd0);
        chk("mid_rst_idx", 32'(if4.idx), 32'd0);
        chk("mid_rst_err", 32'(if4.err_vec), 32'd0);
        @(negedge clk);
        rst4 = 1'b1;
        begin
            int seen_done;
            seen_done = 0;
            repeat (30) begin
                @(posedge clk);
                #1;
                seen_done |= 32'(if4.done) | 32'(if4.busy);
            end
            chk("no_done_after_rst", 32'(seen_done), 32'd0);
        end

        // Reset coincident with start: stays idle.
        @(negedge clk);
        rst4 = 1'b0;
        if4.start = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_start_busy", 32'(if4.busy), 32'd0);
        @(negedge clk);
        rst4 = 1'b1;
        if4.start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_start_idle", 32'({if4.busy, if4.done}), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
